// File: rtl/demo_rst_pkg.sv
// -----------------------------------------------------------------------------
// demo_rst_pkg
// Shared definitions for the DCM reset sequencer (demo_rst):
//   - state_t  : 2-bit state encodings of the sequencer FSM
//   - DEF_*    : default values of the demo_rst parameters
//   - cnt_t    : width of the shared state counter
//   - outs_t   : output bundle decoded from a state
//   - cnt_inc  : saturating counter increment (the counter never wraps)
//   - decode_outs : state -> output decode, applied to the next state so the
//                   registered outputs move on the same edge as the state
// -----------------------------------------------------------------------------
package demo_rst_pkg;

    typedef enum logic [1:0] {
        S_DCMRST = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam int unsigned DEF_DCM_RST_CYCLES = 32'd8;
    localparam int unsigned DEF_HOLD_CYCLES    = 32'd1024;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 32'd65535;

    localparam int unsigned CNT_W = 32'd16;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic dcm_rst;
        logic sys_rst_n;
        logic ready;
    } outs_t;

    // Increment that sticks at all-ones instead of rolling over.
    function automatic cnt_t cnt_inc(input cnt_t c);
        cnt_t res;
        if (c == 16'hFFFF) begin
            res = c;
        end else begin
            res = c + 16'd1;
        end
        return res;
    endfunction

    // Output levels owned by each state; unknown encodings fall back to the
    // safe "DCM held in reset, system held in reset" levels.
    function automatic outs_t decode_outs(input state_t s);
        outs_t o;
        case (s)
            S_DCMRST: begin
                o.dcm_rst   = 1'b1;
                o.sys_rst_n = 1'b0;
                o.ready     = 1'b0;
            end
            S_WAIT, S_HOLD: begin
                o.dcm_rst   = 1'b0;
                o.sys_rst_n = 1'b0;
                o.ready     = 1'b0;
            end
            S_RUN: begin
                o.dcm_rst   = 1'b0;
                o.sys_rst_n = 1'b1;
                o.ready     = 1'b1;
            end
            default: begin
                o.dcm_rst   = 1'b1;
                o.sys_rst_n = 1'b0;
                o.ready     = 1'b0;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/demo_sync2.sv
// -----------------------------------------------------------------------------
// demo_sync2
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Ports:
//   clk   : destination clock
//   rst_n : synchronous active-low reset, clears both flops to 0
//   d     : asynchronous input level
//   q     : synchronized level, 2 clk cycles of latency
// -----------------------------------------------------------------------------
module demo_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Synchronizer chain: meta_r may go metastable, sync_r is the settled copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/demo_rst.sv
// -----------------------------------------------------------------------------
// demo_rst
// DCM reset sequencer. Pulses the DCM reset, waits for LOCKED, requires a
// stable lock for HOLD_CYCLES before releasing the system reset, and re-runs
// the whole sequence if lock is lost while running.
//
// Build option:
//   DEMO_RST_RETRY_EN - when defined, S_WAIT re-pulses the DCM reset after
//                       LOCK_TIMEOUT cycles without lock; when undefined,
//                       S_WAIT waits for lock indefinitely.
//
// Parameters:
//   DCM_RST_CYCLES : CLK cycles DCM_RST is held high per pulse (3..65535)
//   HOLD_CYCLES    : consecutive locked cycles before release   (1..65535)
//   LOCK_TIMEOUT   : S_WAIT cycles before a retry               (1..65535)
//
// Ports:
//   CLK       : board reference clock
//   RST_N     : synchronous active-low reset
//   LOCK      : DCM LOCKED, asynchronous to CLK
//   DCM_RST   : active-high reset to the DCM
//   SYS_RST_N : active-low system reset
//   READY     : high while running
//   LOCK_LOST : sticky, set when lock drops while running; cleared by RST_N
// -----------------------------------------------------------------------------
module demo_rst
    import demo_rst_pkg::*;
#(
    parameter int unsigned DCM_RST_CYCLES = DEF_DCM_RST_CYCLES,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic LOCK,
    output logic DCM_RST,
    output logic SYS_RST_N,
    output logic READY,
    output logic LOCK_LOST
);

`ifdef DEMO_RST_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    // Terminal counts; all counter tests are equality against these.
    localparam cnt_t DCM_LAST     = cnt_t'(DCM_RST_CYCLES - 32'd1);
    localparam cnt_t HOLD_LAST    = cnt_t'(HOLD_CYCLES - 32'd1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 32'd1);

    logic   lock_s;
    logic   wait_timeout_s;
    state_t state_r;
    state_t state_nxt_s;
    cnt_t   cnt_r;
    cnt_t   cnt_nxt_s;
    outs_t  outs_nxt_s;
    logic   dcm_rst_r;
    logic   sys_rst_n_r;
    logic   ready_r;
    logic   lock_lost_r;

    demo_sync2 u_lock_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (LOCK),
        .q     (lock_s)
    );

    // Without the retry option RETRY_EN is 0 and S_WAIT never times out.
    assign wait_timeout_s = RETRY_EN && (cnt_r == TIMEOUT_LAST) && !lock_s;

    // Next-state and next-count logic of the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_DCMRST: begin
                if (cnt_r == DCM_LAST) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_DCMRST;
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_nxt_s = S_HOLD;
                end else if (wait_timeout_s) begin
                    state_nxt_s = S_DCMRST;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_HOLD: begin
                // A lock drop wins over the final hold count.
                if (!lock_s) begin
                    state_nxt_s = S_WAIT;
                end else if (cnt_r == HOLD_LAST) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_nxt_s = S_DCMRST;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            default: begin
                state_nxt_s = S_DCMRST;
            end
        endcase

        // Counter restarts on every state change; it is idle in S_RUN.
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = 16'd0;
        end else if (state_r == S_RUN) begin
            cnt_nxt_s = cnt_r;
        end else begin
            cnt_nxt_s = cnt_inc(cnt_r);
        end

        outs_nxt_s = decode_outs(state_nxt_s);
    end

    // State, counter and outputs; outputs follow the next state.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= S_DCMRST;
            cnt_r       <= 16'd0;
            dcm_rst_r   <= 1'b1;
            sys_rst_n_r <= 1'b0;
            ready_r     <= 1'b0;
            lock_lost_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            dcm_rst_r   <= outs_nxt_s.dcm_rst;
            sys_rst_n_r <= outs_nxt_s.sys_rst_n;
            ready_r     <= outs_nxt_s.ready;
            lock_lost_r <= lock_lost_r
                         | ((state_r == S_RUN) && (state_nxt_s == S_DCMRST));
        end
    end

    assign DCM_RST   = dcm_rst_r;
    assign SYS_RST_N = sys_rst_n_r;
    assign READY     = ready_r;
    assign LOCK_LOST = lock_lost_r;

endmodule

// File: tb/tb_demo_rst.sv
// -----------------------------------------------------------------------------
// tb_demo_rst
// Directed bench for demo_rst with DCM_RST_CYCLES=4, HOLD_CYCLES=16,
// LOCK_TIMEOUT=100. Expected values are hand-derived cycle counts.
// -----------------------------------------------------------------------------
module tb_demo_rst;

    logic clk;
    logic rst_n;
    logic lock;
    logic dcm_rst;
    logic sys_rst_n;
    logic ready;
    logic lock_lost;

    int checks_n = 0;
    int errors_n = 0;

    demo_rst #(
        .DCM_RST_CYCLES (4),
        .HOLD_CYCLES    (16),
        .LOCK_TIMEOUT   (100)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .LOCK      (lock),
        .DCM_RST   (dcm_rst),
        .SYS_RST_N (sys_rst_n),
        .READY     (ready),
        .LOCK_LOST (lock_lost)
    );

    // Free-running reference clock.
    always #5 clk = ~clk;

`ifdef DEMO_RST_RETRY_EN
    localparam int EXP_HIGHS = 11;
    localparam int EXP_RISES = 2;
    localparam int EXP_AT104 = 1;
`else
    localparam int EXP_HIGHS = 3;
    localparam int EXP_RISES = 0;
    localparam int EXP_AT104 = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_n++;
        if (obs !== exp_v) begin
            errors_n++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_dcm, input logic e_srn,
                              input logic e_rdy, input logic e_lost);
        check({tag, ".dcm_rst"},   {31'd0, dcm_rst},   {31'd0, e_dcm});
        check({tag, ".sys_rst_n"}, {31'd0, sys_rst_n}, {31'd0, e_srn});
        check({tag, ".ready"},     {31'd0, ready},     {31'd0, e_rdy});
        check({tag, ".lock_lost"}, {31'd0, lock_lost}, {31'd0, e_lost});
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After release with LOCK low: DCM_RST high after edges 1..3, low at 4.
    task automatic check_dcm_pulse(input string tag);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("%s.dcm_%0d", tag, k), {31'd0, dcm_rst}, {31'd0, (k < 4)});
            check($sformatf("%s.srn_%0d", tag, k), {31'd0, sys_rst_n}, 32'd0);
        end
    endtask

    // LOCK raised and held: release exactly 18 edges after the edge sampling it.
    task automatic check_release(input string tag, input logic e_lost);
        lock = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            tick();
            check($sformatf("%s.srn_%0d", tag, k), {31'd0, sys_rst_n}, {31'd0, (k == 18)});
            check($sformatf("%s.rdy_%0d", tag, k), {31'd0, ready}, {31'd0, (k == 18)});
        end
        check({tag, ".lost"}, {31'd0, lock_lost}, {31'd0, e_lost});
    endtask

    initial begin
        int highs;
        int rises;
        int at104;
        logic prev;

        clk   = 1'b0;
        rst_n = 1'b0;
        lock  = 1'b0;
        repeat (3) tick();
        check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0);

        // First DCM pulse, then ten idle cycles with DCM released.
        rst_n = 1'b1;
        check_dcm_pulse("pulse1");
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("wait.dcm_%0d", k), {31'd0, dcm_rst}, 32'd0);
        end
        check_release("lockup1", 1'b0);

        // Lock lost while running: effect lands 2 edges later, new pulse.
        lock = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            tick();
            check($sformatf("loss.srn_%0d", k), {31'd0, sys_rst_n}, {31'd0, (k < 2)});
            check($sformatf("loss.rdy_%0d", k), {31'd0, ready}, {31'd0, (k < 2)});
            check($sformatf("loss.lost_%0d", k), {31'd0, lock_lost}, {31'd0, (k >= 2)});
            check($sformatf("loss.dcm_%0d", k), {31'd0, dcm_rst}, {31'd0, (k >= 2 && k <= 5)});
        end
        repeat (3) tick();
        check_release("relock", 1'b1);

        // One-cycle reset while running aborts to reset values.
        rst_n = 1'b0;
        tick();
        check_outs("midreset", 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        lock  = 1'b0;
        check_dcm_pulse("pulse2");

        // Hold interrupted at count 10: release delayed to edge 30.
        for (int k = 0; k <= 30; k++) begin
            lock = (k != 11);
            tick();
            check($sformatf("holdrestart.srn_%0d", k), {31'd0, sys_rst_n}, {31'd0, (k >= 30)});
        end
        check("holdrestart.lost", {31'd0, lock_lost}, 32'd0);

        // LOCK stuck low: count DCM pulses over 215 cycles.
        rst_n = 1'b0;
        lock  = 1'b0;
        tick();
        rst_n = 1'b1;
        highs = 0;
        rises = 0;
        at104 = 0;
        prev  = 1'b1;
        for (int k = 1; k <= 215; k++) begin
            tick();
            if (dcm_rst) highs++;
            if (dcm_rst && !prev) rises++;
            if (k == 104) at104 = int'(dcm_rst);
            prev = dcm_rst;
        end
        check("retry.highs", highs, EXP_HIGHS);
        check("retry.rises", rises, EXP_RISES);
        check("retry.dcm_at_104", at104, EXP_AT104);
        check("retry.srn", {31'd0, sys_rst_n}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule

// File: doc/demo_rst.md
DEMO_RST -- requirements
Module: demo_rst

Interface
REQ-001 Parameter DCM_RST_CYCLES, default 8: number of CLK cycles DCM_RST is held high per DCM reset pulse (legal 3..65535).
REQ-002 Parameter HOLD_CYCLES, default 1024: consecutive synchronized-lock cycles required before system reset release (legal 1..65535).
REQ-003 Parameter LOCK_TIMEOUT, default 65535: cycles allowed in S_WAIT before a DCM reset retry (legal 1..65535; used only with retry enabled).
REQ-004 CLK  input  1  board reference clock (pre-DCM input domain); one clock only.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 LOCK  input  1  DCM LOCKED, asynchronous to CLK.
REQ-007 DCM_RST  output  1  active-high reset to the DCM RST pin.
REQ-008 SYS_RST_N  output  1  active-low system reset to the core and peripherals.
REQ-009 READY  output  1  high while in S_RUN.
REQ-010 LOCK_LOST  output  1  sticky flag: lock dropped while in S_RUN; cleared only by RST_N.

Function
REQ-011 LOCK shall pass through a 2-flop synchronizer (lock_s), giving 2 cycles of latency; all decisions shall use lock_s only.
REQ-012 FSM states: S_DCMRST, S_WAIT, S_HOLD, S_RUN; one 16-bit counter cnt, cleared on every state change.
REQ-013 S_DCMRST: DCM_RST=1; cnt increments; at cnt==DCM_RST_CYCLES-1 -> S_WAIT.
REQ-014 S_WAIT: DCM_RST=0; lock_s=1 -> S_HOLD; with retry enabled, cnt==LOCK_TIMEOUT-1 and lock_s=0 -> S_DCMRST.
REQ-015 S_HOLD: cnt increments while lock_s=1; lock_s=0 -> S_WAIT (count restarts from 0); at cnt==HOLD_CYCLES-1 with lock_s=1 -> S_RUN.
REQ-016 S_RUN: SYS_RST_N=1, READY=1; lock_s=0 -> S_DCMRST and LOCK_LOST set in the same clock edge.
REQ-017 All outputs shall be registered and decoded from the next state, so they change on the same edge as the state transition.
REQ-018 SYS_RST_N=0 and READY=0 in every state except S_RUN.
REQ-019 Lock-timeout and lock-loss occurring in the same cycle is impossible by state; lock_s dropping on the final S_HOLD count shall go to S_WAIT, not S_RUN.
REQ-020 cnt shall never wrap; comparisons are equality against parameter-1.

Reset
REQ-021 When RST_N=0 is sampled: state=S_DCMRST, cnt=0, DCM_RST=1, SYS_RST_N=0, READY=0, LOCK_LOST=0, synchronizer flops=0.
REQ-022 Reset asserted mid-operation (including in S_RUN) shall abort immediately to the REQ-021 values on the next edge; the DCM reset pulse restarts in full after release.

Configuration
REQ-023 Macro DEMO_RST_RETRY_EN: when defined, the S_WAIT timeout retry of REQ-014 is compiled in; when undefined, S_WAIT waits indefinitely for lock, and LOCK_TIMEOUT is ignored.

Structure
REQ-024 State encodings (2-bit) and default parameter values shall reside in the shared include file demo_defines.v.
REQ-025 The synchronizer shall be a sub-module demo_sync2 (1-bit, 2 flops, synchronous active-low reset to 0); everything else stays in demo_rst.

Verification (DCM_RST_CYCLES=4, HOLD_CYCLES=16, LOCK_TIMEOUT=100)
REQ-026 Release RST_N with LOCK=0 -> DCM_RST high for exactly 4 cycles after release, then 0; SYS_RST_N stays 0.
REQ-027 Raise LOCK 10 cycles after DCM_RST falls and hold it -> SYS_RST_N and READY rise exactly 2+16 cycles after the LOCK edge; LOCK_LOST=0.
REQ-028 In S_HOLD, drop LOCK for 1 cycle at hold count 10 -> no release; the full 16-cycle hold restarts after lock returns.
REQ-029 In S_RUN, drop LOCK -> 2 cycles later SYS_RST_N=0, READY=0, LOCK_LOST=1, and a new 4-cycle DCM_RST pulse begins; after relock, release occurs again and LOCK_LOST remains 1.
REQ-030 With DEMO_RST_RETRY_EN defined and LOCK held 0 -> DCM_RST re-pulses every 104 cycles; with it undefined -> a single pulse only.
REQ-031 Assert RST_N=0 for 1 cycle while in S_RUN -> all outputs match REQ-021 on the next edge; the sequence restarts from REQ-026.
